// File: rtl/core_pkg.sv
// Shared types and helpers for the pipeline control slice: forwarding selects,
// hazard FSM states and the operand-forwarding priority function.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // Memory-stage result is younger than writeback, so it wins; x0 never forwards.
  function automatic fwd_sel_e fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  wr_m,
    input logic                  wr_w
  );
    if (wr_m && (rs == rd_m) && (rs != '0)) return FWD_MEM;
    if (wr_w && (rs == rd_w) && (rs != '0)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stall and flush,
// data-memory wait FSM with timeout, and stall/flush performance counters.
module hazard_unit
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  ResultSrcEb0,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  input  logic                  CntClr,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  MemErr,
  output logic [CNT_W-1:0]      StallCnt,
  output logic [CNT_W-1:0]      FlushCnt
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e       r_state, w_state_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_mem_err, w_mem_err_nxt;
  logic            w_lw_stall;
  logic            w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic            w_flush_d, w_flush_e, w_flush_w;
  fwd_sel_e        w_fwd_a, w_fwd_b;

  assign w_fwd_a    = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
  assign w_fwd_b    = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
  assign w_lw_stall = ResultSrcEb0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_to_cnt  <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end

  // Next state and stage controls; the entry and exit cycles of a memory wait
  // both drive the full stall so the pipeline freezes with zero latency.
  always_comb begin
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = r_to_cnt;
    w_mem_err_nxt = r_mem_err;
    w_stall_f     = 1'b0;
    w_stall_d     = 1'b0;
    w_stall_e     = 1'b0;
    w_stall_m     = 1'b0;
    w_flush_d     = 1'b0;
    w_flush_e     = 1'b0;
    w_flush_w     = 1'b0;
    case (r_state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          w_state_nxt  = MEM_WAIT;
          w_to_cnt_nxt = TO_W'(1);
          w_stall_f    = 1'b1;
          w_stall_d    = 1'b1;
          w_stall_e    = 1'b1;
          w_stall_m    = 1'b1;
          w_flush_w    = 1'b1;
        end else begin
          w_stall_f = w_lw_stall;
          w_stall_d = w_lw_stall;
          w_flush_d = PCSrcE;
          w_flush_e = w_lw_stall || PCSrcE;
        end
      end
      MEM_WAIT: begin
        if (!MemReadyM && (r_to_cnt == TO_W'(MEM_TIMEOUT))) begin
          w_state_nxt   = RUN;
          w_to_cnt_nxt  = '0;
          w_mem_err_nxt = 1'b1;
          w_flush_w     = 1'b1;
        end else begin
          if (MemReadyM) begin
            w_state_nxt  = RUN;
            w_to_cnt_nxt = '0;
          end else begin
            w_to_cnt_nxt = r_to_cnt + TO_W'(1);
          end
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_stall_m = 1'b1;
          w_flush_w = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // While reset is held every stage is bubbled and nothing forwards.
  assign ForwardAE = reset ? w_fwd_a : FWD_RF;
  assign ForwardBE = reset ? w_fwd_b : FWD_RF;
  assign StallF    = reset & w_stall_f;
  assign StallD    = reset & w_stall_d;
  assign StallE    = reset & w_stall_e;
  assign StallM    = reset & w_stall_m;
  assign FlushD    = ~reset | w_flush_d;
  assign FlushE    = ~reset | w_flush_e;
  assign FlushW    = ~reset | w_flush_w;
  assign MemErr    = r_mem_err;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (CntClr),
    .inc   (StallF),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (CntClr),
    .inc   (FlushD),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with 4-bit counters and a 16-cycle memory timeout.
module tb_hazard_unit;

  localparam int unsigned CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, MemReqM, MemReadyM, CntClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  hazard_unit #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClr(CntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcEb0 = 1'b0;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0; CntClr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stalls(input string tag, input logic exp);
    check({tag, "_stallf"}, 32'(StallF), 32'(exp));
    check({tag, "_stalld"}, 32'(StallD), 32'(exp));
    check({tag, "_stalle"}, 32'(StallE), 32'(exp));
    check({tag, "_stallm"}, 32'(StallM), 32'(exp));
  endtask

  initial begin
    idle();
    reset = 1'b0;
    RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7;
    #3;
    check("rst_flushd", 32'(FlushD), 32'd1);
    check("rst_flushe", 32'(FlushE), 32'd1);
    check("rst_flushw", 32'(FlushW), 32'd1);
    check_stalls("rst", 1'b0);
    check("rst_fwda", 32'(ForwardAE), 32'd0);
    check("rst_memerr", 32'(MemErr), 32'd0);
    check("rst_stallcnt", 32'(StallCnt), 32'd0);
    check("rst_flushcnt", 32'(FlushCnt), 32'd0);

    // Release reset between edges, then exercise forwarding combinationally.
    #4; reset = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd7; RegWriteW = 1'b1; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7;
    #1;
    check("fwd_mem_a", 32'(ForwardAE), 32'd2);
    check("fwd_mem_b", 32'(ForwardBE), 32'd2);
    check("run_flushd", 32'(FlushD), 32'd0);
    check("run_flushw", 32'(FlushW), 32'd0);
    RdM = 5'd0; Rs1E = 5'd0;
    #1;
    check("fwd_x0_a", 32'(ForwardAE), 32'd0);
    check("fwd_wb_b", 32'(ForwardBE), 32'd1);
    RdM = 5'd3; Rs1E = 5'd3; RegWriteW = 1'b0;
    #1;
    check("fwd_mem3_a", 32'(ForwardAE), 32'd2);
    check("fwd_nowr_b", 32'(ForwardBE), 32'd0);
    idle();
    cyc();
    check("idle_stallcnt", 32'(StallCnt), 32'd0);

    // Load-use hazard on x5.
    ResultSrcEb0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    #1;
    check("lu_stallf", 32'(StallF), 32'd1);
    check("lu_stalld", 32'(StallD), 32'd1);
    check("lu_flushe", 32'(FlushE), 32'd1);
    check("lu_flushd", 32'(FlushD), 32'd0);
    check("lu_stalle", 32'(StallE), 32'd0);
    cyc();
    idle();
    ResultSrcEb0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    check("lu_x0_stallf", 32'(StallF), 32'd0);
    check("lu_stallcnt", 32'(StallCnt), 32'd1);
    check("lu_flushcnt", 32'(FlushCnt), 32'd0);
    idle();

    // Taken branch.
    PCSrcE = 1'b1;
    #1;
    check("br_flushd", 32'(FlushD), 32'd1);
    check("br_flushe", 32'(FlushE), 32'd1);
    check_stalls("br", 1'b0);
    cyc();
    idle();
    #1;
    check("br_flushcnt", 32'(FlushCnt), 32'd1);
    check("br_stallcnt", 32'(StallCnt), 32'd1);

    // Branch together with load-use.
    PCSrcE = 1'b1; ResultSrcEb0 = 1'b1; RdE = 5'd9; Rs2D = 5'd9;
    #1;
    check("both_flushd", 32'(FlushD), 32'd1);
    check("both_flushe", 32'(FlushE), 32'd1);
    check("both_stallf", 32'(StallF), 32'd1);
    check("both_stalld", 32'(StallD), 32'd1);
    cyc();
    idle();
    #1;
    check("both_stallcnt", 32'(StallCnt), 32'd2);
    check("both_flushcnt", 32'(FlushCnt), 32'd2);

    // Memory wait: three not-ready cycles then ready.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) PCSrcE = 1'b1;
      #1;
      check_stalls($sformatf("mw%0d", i), 1'b1);
      check($sformatf("mw%0d_flushw", i), 32'(FlushW), 32'd1);
      check($sformatf("mw%0d_flushd", i), 32'(FlushD), 32'd0);
      check($sformatf("mw%0d_flushe", i), 32'(FlushE), 32'd0);
      cyc();
    end
    MemReadyM = 1'b1;
    #1;
    check_stalls("mw_rdy", 1'b1);
    check("mw_rdy_flushw", 32'(FlushW), 32'd1);
    cyc();
    idle();
    #1;
    check_stalls("mw_done", 1'b0);
    check("mw_done_flushw", 32'(FlushW), 32'd0);
    check("mw_done_memerr", 32'(MemErr), 32'd0);
    check("mw_stallcnt", 32'(StallCnt), 32'd6);
    check("mw_flushcnt", 32'(FlushCnt), 32'd2);

    // Timeout: 16 stalled cycles, then an abort cycle with stalls released.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("to%0d_stallm", k), 32'(StallM), 32'd1);
      cyc();
      MemReqM = 1'b0;
    end
    #1;
    check_stalls("to_abort", 1'b0);
    check("to_abort_flushw", 32'(FlushW), 32'd1);
    check("to_abort_memerr", 32'(MemErr), 32'd0);
    cyc();
    #1;
    check("to_memerr", 32'(MemErr), 32'd1);
    check("to_run_flushw", 32'(FlushW), 32'd0);
    check("to_run_stallf", 32'(StallF), 32'd0);
    check("sat_stallcnt", 32'(StallCnt), 32'hF);
    cyc(); cyc();
    check("sticky_memerr", 32'(MemErr), 32'd1);
    check("sat_hold", 32'(StallCnt), 32'hF);

    // Clear has priority over an active stall increment.
    ResultSrcEb0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4; CntClr = 1'b1;
    cyc();
    #1;
    check("clr_stallcnt", 32'(StallCnt), 32'd0);
    check("clr_flushcnt", 32'(FlushCnt), 32'd0);
    CntClr = 1'b0;
    cyc();
    check("postclr_stallcnt", 32'(StallCnt), 32'd1);
    idle();

    // Reset while waiting on memory.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    cyc();
    MemReqM = 1'b0;
    #1;
    check("mwr_stallf", 32'(StallF), 32'd1);
    reset = 1'b0;
    #1;
    check_stalls("mwr_rst", 1'b0);
    check("mwr_rst_flushd", 32'(FlushD), 32'd1);
    check("mwr_rst_flushw", 32'(FlushW), 32'd1);
    check("mwr_rst_memerr", 32'(MemErr), 32'd0);
    check("mwr_rst_stallcnt", 32'(StallCnt), 32'd0);
    reset = 1'b1;
    #1;
    check("mwr_run_stallf", 32'(StallF), 32'd0);
    check("mwr_run_flushw", 32'(FlushW), 32'd0);
    cyc();
    check("mwr_run2_stallm", 32'(StallM), 32'd0);
    check("mwr_run2_memerr", 32'(MemErr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer side of the pipeline control interface: takes the controller's hazard outputs (RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE) plus register addresses from the datapath.
- Returns forwarding selects, per-stage stall/flush (FlushE feeds back into the controller's ID/EX control registers) and a data-memory wait FSM.
- Sits beside controller and datapath in the 5-stage core top; also keeps saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before error abort
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock, all state rises on posedge
reset  in  1  asynchronous, active-low reset (0 = reset)
Rs1D  in  5  rs1 address in Decode
Rs2D  in  5  rs2 address in Decode
Rs1E  in  5  rs1 address in Execute
Rs2E  in  5  rs2 address in Execute
RdE  in  5  destination in Execute
RdM  in  5  destination in Memory
RdW  in  5  destination in Writeback
RegWriteM  in  1  Memory-stage write enable (from controller)
RegWriteW  in  1  Writeback-stage write enable (from controller)
ResultSrcEb0  in  1  Execute instruction is a load
PCSrcE  in  1  taken branch/jump resolved in Execute
MemReqM  in  1  Memory stage issuing load/store this cycle
MemReadyM  in  1  data memory completes access this cycle
CntClr  in  1  synchronous clear of performance counters
ForwardAE  out  2  ALU operand A select
ForwardBE  out  2  ALU operand B select
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  bubble IF/ID
FlushE  out  1  bubble ID/EX
FlushW  out  1  bubble MEM/WB
MemErr  out  1  sticky timeout flag
StallCnt  out  CNT_W  cycles with StallF=1
FlushCnt  out  CNT_W  cycles with FlushD=1

Behaviour:
- Forwarding (combinational, always active):
  - ForwardAE = 2'b10 if RegWriteM & Rs1E==RdM & Rs1E!=0.
  - Else 2'b01 if RegWriteW & Rs1E==RdW & Rs1E!=0.
  - Else 2'b00.
  - ForwardBE identical using Rs2E. M has priority over W.
- Load-use: lwStall = ResultSrcEb0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- FSM states RUN, MEM_WAIT; register state, timeout counter (clog2(MEM_TIMEOUT+1) bits), MemErr, counters.
- RUN outputs:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - StallE = StallM = FlushW = 0.
- RUN -> MEM_WAIT when MemReqM & !MemReadyM; timeout counter loads 1.
- MEM_WAIT outputs:
  - StallF = StallD = StallE = StallM = 1, FlushW = 1.
  - FlushD = FlushE = 0; a pending PCSrcE flush is deferred because E is held and PCSrcE persists.
  - Load-use stall is subsumed.
- The transition cycle itself (RUN with MemReqM & !MemReadyM) also drives the MEM_WAIT outputs combinationally, so stall is zero-latency.
- MEM_WAIT -> RUN when MemReadyM. That cycle still drives MEM_WAIT outputs; the pipeline advances on the next edge.
- MEM_WAIT -> RUN when the timeout counter reaches MEM_TIMEOUT without MemReadyM:
  - MemErr sets (sticky until reset).
  - That cycle outputs FlushW=1 with stalls released.
- Counters:
  - StallCnt increments when StallF=1; FlushCnt increments when FlushD=1.
  - Both saturate at all-ones.
  - CntClr has priority over increment, clearing to 0.
- Reset (reset=0, asynchronous):
  - State RUN, timeout counter 0, MemErr 0, StallCnt 0, FlushCnt 0.
  - While reset=0, outputs are forced to: FlushD=1, FlushE=1, FlushW=1, all stalls 0, ForwardAE = ForwardBE = 0.
  - Reset mid-MEM_WAIT aborts to RUN with no MemErr.
- Simultaneous lwStall & PCSrcE in RUN: FlushD=1, FlushE=1, StallF=StallD=1. The branch wins; IF/ID is flushed, so the stall is harmless.

Decomposition:
- core_pkg:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - hz_state_e enum: RUN, MEM_WAIT.
  - REG_ADDR_W=5.
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, count), instantiated twice.

Test Plan:
- Load x5 in E (ResultSrcEb0=1, RdE=5), Rs1D=5 -> StallF=StallD=1, FlushE=1 for one cycle, StallCnt +1.
- RegWriteM=1, RdM=7, RegWriteW=1, RdW=7, Rs1E=7, Rs2E=7 -> ForwardAE=ForwardBE=2'b10. Repeat with RdM=0/Rs1E=0 -> 2'b00.
- PCSrcE=1 in RUN -> FlushD=FlushE=1, no stalls, FlushCnt +1.
- MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..StallM=1 and FlushW=1 for 4 cycles; RUN afterwards; MemErr=0.
- MemReadyM held 0 with MEM_TIMEOUT=16 -> MemErr=1 after 16 wait cycles, stalls release, MemErr stays 1 until reset.
- Assert reset=0 mid-MEM_WAIT; set CntClr during stall streak; drive counters to saturation with CNT_W=4 -> respectively: immediate RUN and cleared counters; counters read 0 next cycle; counter holds at 4'hF.
